// File: rtl/pong_pkg.sv
// Shared definitions for the Pong input-conditioning stage: channel map,
// debounce filter state encoding and default debounce length.
`default_nettype none

package pong_pkg;

  localparam int CH_START = 0;
  localparam int CH_UP_P1 = 1;
  localparam int CH_DN_P1 = 2;
  localparam int CH_UP_P2 = 3;
  localparam int CH_DN_P2 = 4;
  localparam int NUM_CH   = 5;

  // 10 ms at a 25 MHz pixel clock
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

  typedef enum logic {
    DEB_STABLE  = 1'b0,
    DEB_PENDING = 1'b1
  } deb_state_e;

endpackage

`default_nettype wire

// File: rtl/pong_debounce_filter.sv
// One input channel: multi-stage synchronizer followed by a counter filter
// that flips the stable value after DEBOUNCE_CYCLES consecutive differing samples.
`default_nettype none

module pong_debounce_filter
  import pong_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   stable_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DEB_STABLE;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      stable <= stable_next;
    end
  end

  // The counter tops out at DEBOUNCE_CYCLES-1, so it can never wrap.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stable_next = stable;
    case (state)
      DEB_STABLE: begin
        if (sync != stable) begin
          state_next = DEB_PENDING;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      DEB_PENDING: begin
        if (sync == stable) begin
          state_next = DEB_STABLE;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next  = DEB_STABLE;
          cnt_next    = '0;
          stable_next = ~stable;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = DEB_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pong_input_cond.sv
// Pong input conditioning: debounces the five board buttons, gates conflicting
// paddle directions and turns the start button into a single-cycle pulse.
`default_nettype none

module pong_input_cond
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic Game_Start_raw_i,
  input  logic Paddle_Up_P1_raw_i,
  input  logic Paddle_Down_P1_raw_i,
  input  logic Paddle_Up_P2_raw_i,
  input  logic Paddle_Down_P2_raw_i,
  output logic Game_Start_o,
  output logic Paddle_Up_P1_o,
  output logic Paddle_Down_P1_o,
  output logic Paddle_Up_P2_o,
  output logic Paddle_Down_P2_o
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] cond;
  logic [NUM_CH-1:0] stable;
  logic              start_d;
  logic              up_p1, dn_p1, up_p2, dn_p2;

  assign raw[CH_START] = Game_Start_raw_i;
  assign raw[CH_UP_P1] = Paddle_Up_P1_raw_i;
  assign raw[CH_DN_P1] = Paddle_Down_P1_raw_i;
  assign raw[CH_UP_P2] = Paddle_Up_P2_raw_i;
  assign raw[CH_DN_P2] = Paddle_Down_P2_raw_i;

  assign cond = ACTIVE_LOW ? ~raw : raw;

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      pong_debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk   (clk_i),
        .rst   (rst_i),
        .din   (cond[ch]),
        .stable(stable[ch])
      );
    end
  endgenerate

  // Both directions held on one paddle cancel to no motion.
  assign up_p1 = stable[CH_UP_P1] & ~stable[CH_DN_P1];
  assign dn_p1 = stable[CH_DN_P1] & ~stable[CH_UP_P1];
  assign up_p2 = stable[CH_UP_P2] & ~stable[CH_DN_P2];
  assign dn_p2 = stable[CH_DN_P2] & ~stable[CH_UP_P2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_d          <= 1'b0;
      Game_Start_o     <= 1'b0;
      Paddle_Up_P1_o   <= 1'b0;
      Paddle_Down_P1_o <= 1'b0;
      Paddle_Up_P2_o   <= 1'b0;
      Paddle_Down_P2_o <= 1'b0;
    end else begin
      start_d          <= stable[CH_START];
      Game_Start_o     <= stable[CH_START] & ~start_d;
      Paddle_Up_P1_o   <= up_p1;
      Paddle_Down_P1_o <= dn_p1;
      Paddle_Up_P2_o   <= up_p2;
      Paddle_Down_P2_o <= dn_p2;
    end
  end

endmodule

`default_nettype wire
